tri_port_regfile_ctrl: RTL
==========================

TRI_PORT_REGFILE_CTRL -- requirements
Module: tri_port_regfile_ctrl

Interface
REQ-001 SHALL have parameter SINGLE_ENTRY_SIZE_IN_BITS, default 8, entry data width.
REQ-002 SHALL have parameter NUMBER_ENTRY, default 4, number of regfile entries.
REQ-003 SHALL have parameter NUMBER_ENTRY_LOG2, default 2, binary address width.
REQ-004 SHALL have ports, one clock domain; reset is asynchronous, active-low:
- clk_in  in  1  clock
- reset_in  in  1  asynchronous active-low reset
- request_valid_in  in  1  request present
- request_ready_out  out  1  controller can accept
- request_op_in  in  2  00 read, 01 write, 10 cam, 11 reserved
- request_addr_in  in  NUMBER_ENTRY_LOG2  binary entry address
- request_data_in  in  SINGLE_ENTRY_SIZE_IN_BITS  write data or cam key
- response_valid_out  out  1  response present
- response_ready_in  in  1  consumer accepts response
- response_data_out  out  SINGLE_ENTRY_SIZE_IN_BITS  read data
- response_hit_out  out  1  cam hit
- response_index_out  out  NUMBER_ENTRY_LOG2  encoded cam hit index
- response_error_out  out  1  invalid-entry read or reserved op
- read_en_out, write_en_out, cam_en_out  out  1 each  regfile port enables
- read_entry_addr_decoded_out, write_entry_addr_decoded_out  out  NUMBER_ENTRY  one-hot addresses
- cam_entry_out, write_entry_out  out  SINGLE_ENTRY_SIZE_IN_BITS  cam key, write data
- read_entry_in  in  SINGLE_ENTRY_SIZE_IN_BITS  regfile read data, valid one cycle after read_en
- cam_result_decoded_in  in  NUMBER_ENTRY  regfile match vector, valid one cycle after cam_en
- entry_valid_flatted_in  in  NUMBER_ENTRY  regfile per-entry valid bits

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one transition per cycle except RESP.
REQ-006 request_ready_out SHALL be 1 only in IDLE; a request is accepted on valid&&ready (cycle T) and op/addr/data are registered.
REQ-007 In ISSUE (T+1), the enable matching the op SHALL be 1 for exactly one cycle with the one-hot address and data driven; all enables SHALL be 0 in every other state.
REQ-008 Decoded address outputs SHALL be 1<<addr during ISSUE and 0 otherwise; data outputs SHALL be 0 outside ISSUE.
REQ-009 In WAIT (T+2), read_entry_in, cam_result_decoded_in and entry_valid_flatted_in SHALL be sampled at the clock edge closing the cycle.
REQ-010 response_valid_out SHALL rise at T+3 and hold, with all response fields stable, until response_valid_out&&response_ready_in; FSM returns to IDLE on the following edge.
REQ-011 Read: response_data_out = sampled data; if entry_valid bit [addr] was 0, response_error_out=1 and response_data_out=0.
REQ-012 Write: response is an acknowledge, data/hit/index/error all 0.
REQ-013 Cam: response_hit_out = OR of sampled match vector; response_index_out = lowest set bit index (see REQ-017); no hit gives index 0.
REQ-014 Reserved op 11: no enable asserted in ISSUE; response at T+3 with response_error_out=1, other fields 0.
REQ-015 Addresses >= NUMBER_ENTRY SHALL be treated as reserved op (error, no enables).

Reset
REQ-016 reset_in low SHALL immediately force FSM to IDLE, all outputs to 0 except request_ready_out which becomes 1 after release, drop any in-flight request, produce no response.

Configuration
REQ-017 Macro TRI_PORT_REGFILE_CTRL_CAM_HIGH_PRIORITY_EN: defined, multi-hit cam reports highest set index; undefined, lowest set index.

Verification
REQ-018 Write addr 2, data 0xA5 -> at T+1 write_en_out=1, write_entry_addr_decoded_out=4'b0100, write_entry_out=0xA5; T+3 response_valid=1, error=0.
REQ-019 Read addr 2, entry_valid=4'b0100, read_entry_in=0xA5 -> response_data_out=0xA5, error=0; read addr 1 -> data 0x00, error=1.
REQ-020 Cam key 0x3C, cam_result_decoded_in=4'b1010 -> cam_en_out pulse, cam_entry_out=0x3C; hit=1, index=1 (macro undefined) or 3 (defined); result 4'b0000 -> hit=0, index=0.
REQ-021 response_ready_in held 0 for 5 cycles -> response fields constant, request_ready_out=0, no enables; release -> IDLE next cycle.
REQ-022 reset_in low during WAIT of a read -> all outputs 0 same cycle; after release request_ready_out=1, no response ever issued.
REQ-023 Op 11, addr 0 -> no enable ever asserted; response at T+3 with error=1.

Source files
------------

// File: rtl/tri_port_regfile_ctrl.sv
// tri_port_regfile_ctrl
//   Sequences single requests (read / write / cam) onto a tri-port register
//   file and returns one response per request through a valid/ready handshake.
//   Per request: IDLE (accept) -> ISSUE (port enable pulse) -> WAIT (sample
//   regfile outputs) -> RESP (hold response until accepted) -> IDLE.
//
// Ports
//   clk_in, reset_in             clock, asynchronous active-low reset
//   request_*                    request channel (op 00 rd, 01 wr, 10 cam, 11 rsvd)
//   response_*                   response channel (data, cam hit/index, error)
//   read_/write_/cam_en_out      regfile port enables, one-cycle pulse in ISSUE
//   *_entry_addr_decoded_out     one-hot entry address of the active port
//   cam_entry_out/write_entry_out cam key / write data of the active port
//   read_entry_in                regfile read data, one cycle after read_en
//   cam_result_decoded_in        regfile match vector, one cycle after cam_en
//   entry_valid_flatted_in       regfile per-entry valid bits
//
// Configuration macro
//   TRI_PORT_REGFILE_CTRL_CAM_HIGH_PRIORITY_EN : multi-hit cam reports the
//   highest matching index; when undefined, the lowest.
module tri_port_regfile_ctrl #(
   parameter int SINGLE_ENTRY_SIZE_IN_BITS = 8,
   parameter int NUMBER_ENTRY              = 4,
   parameter int NUMBER_ENTRY_LOG2         = 2
) (
   input  logic                                 clk_in,
   input  logic                                 reset_in,
   input  logic                                 request_valid_in,
   output logic                                 request_ready_out,
   input  logic [1:0]                           request_op_in,
   input  logic [NUMBER_ENTRY_LOG2-1:0]         request_addr_in,
   input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
   output logic                                 response_valid_out,
   input  logic                                 response_ready_in,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out,
   output logic                                 response_hit_out,
   output logic [NUMBER_ENTRY_LOG2-1:0]         response_index_out,
   output logic                                 response_error_out,
   output logic                                 read_en_out,
   output logic                                 write_en_out,
   output logic                                 cam_en_out,
   output logic [NUMBER_ENTRY-1:0]              read_entry_addr_decoded_out,
   output logic [NUMBER_ENTRY-1:0]              write_entry_addr_decoded_out,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] cam_entry_out,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_out,
   input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_in,
   input  logic [NUMBER_ENTRY-1:0]              cam_result_decoded_in,
   input  logic [NUMBER_ENTRY-1:0]              entry_valid_flatted_in
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                                 state, state_next;
   logic [1:0]                             op;
   logic [NUMBER_ENTRY_LOG2-1:0]           addr;
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   data;
   logic                                   bad;
   logic                                   accept;
   logic                                   issue;
   logic [NUMBER_ENTRY-1:0]                onehot;
   logic [NUMBER_ENTRY_LOG2-1:0]           cam_index;
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]   rsp_data;
   logic                                   rsp_hit;
   logic [NUMBER_ENTRY_LOG2-1:0]           rsp_index;
   logic                                   rsp_error;

   // Ready is held low while reset is asserted so every output reads 0.
   assign request_ready_out = (state == IDLE) && reset_in;
   assign accept            = request_valid_in && request_ready_out;

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) state <= IDLE;
      else           state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    state_next = RESP;
         RESP:    if (response_ready_in) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request capture; out-of-range addresses are folded into the reserved-op path.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         op   <= '0;
         addr <= '0;
         data <= '0;
         bad  <= 1'b0;
      end else if (accept) begin
         op   <= request_op_in;
         addr <= request_addr_in;
         data <= request_data_in;
         bad  <= (request_op_in == 2'b11) || (32'(request_addr_in) >= NUMBER_ENTRY);
      end
   end

   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NUMBER_ENTRY; i++)
         onehot[i] = (addr == NUMBER_ENTRY_LOG2'(i));
   end

   assign issue        = (state == ISSUE) && !bad;
   assign read_en_out  = issue && (op == 2'b00);
   assign write_en_out = issue && (op == 2'b01);
   assign cam_en_out   = issue && (op == 2'b10);

   assign read_entry_addr_decoded_out  = read_en_out  ? onehot : '0;
   assign write_entry_addr_decoded_out = write_en_out ? onehot : '0;
   assign write_entry_out              = write_en_out ? data   : '0;
   assign cam_entry_out                = cam_en_out   ? data   : '0;

   // Priority encoder: the last assignment in loop order wins.
   always_comb begin
      cam_index = '0;
`ifdef TRI_PORT_REGFILE_CTRL_CAM_HIGH_PRIORITY_EN
      for (int unsigned i = 0; i < NUMBER_ENTRY; i++)
         if (cam_result_decoded_in[i]) cam_index = NUMBER_ENTRY_LOG2'(i);
`else
      for (int unsigned i = NUMBER_ENTRY; i > 0; i--)
         if (cam_result_decoded_in[i-1]) cam_index = NUMBER_ENTRY_LOG2'(i-1);
`endif
   end

   // Regfile outputs are sampled on the edge closing WAIT and held through RESP.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         rsp_data  <= '0;
         rsp_hit   <= 1'b0;
         rsp_index <= '0;
         rsp_error <= 1'b0;
      end else if (state == WAIT) begin
         rsp_data  <= '0;
         rsp_hit   <= 1'b0;
         rsp_index <= '0;
         rsp_error <= 1'b0;
         if (bad) begin
            rsp_error <= 1'b1;
         end else begin
            unique case (op)
               2'b00: begin
                  if (entry_valid_flatted_in[addr]) rsp_data  <= read_entry_in;
                  else                              rsp_error <= 1'b1;
               end
               2'b10: begin
                  rsp_hit   <= |cam_result_decoded_in;
                  rsp_index <= cam_index;
               end
               default: ;
            endcase
         end
      end
   end

   assign response_valid_out = (state == RESP);
   assign response_data_out  = response_valid_out ? rsp_data  : '0;
   assign response_hit_out   = response_valid_out && rsp_hit;
   assign response_index_out = response_valid_out ? rsp_index : '0;
   assign response_error_out = response_valid_out && rsp_error;

endmodule
